// File: rtl/bf_pkg.sv
// bf_pkg: op codes, command byte constants and FSM states shared by the bfX fetch stage
package bf_pkg;
    typedef enum logic [2:0] {
        INC, DEC, RIGHT, LEFT, OUT, IN, LOOP_OPEN, LOOP_CLOSE
    } op_t;
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_SCAN_REQ, S_SCAN_CHK, S_HALT
    } state_t;
    localparam logic [7:0] CH_INC   = 8'h2B;
    localparam logic [7:0] CH_DEC   = 8'h2D;
    localparam logic [7:0] CH_RIGHT = 8'h3E;
    localparam logic [7:0] CH_LEFT  = 8'h3C;
    localparam logic [7:0] CH_OUT   = 8'h2E;
    localparam logic [7:0] CH_IN    = 8'h2C;
    localparam logic [7:0] CH_OPEN  = 8'h5B;
    localparam logic [7:0] CH_CLOSE = 8'h5D;
    localparam logic [7:0] CH_NUL   = 8'h00;
endpackage

// File: rtl/bf_decode.sv
// bf_decode: maps a program byte to {is_op, op_code}; data in, is_op/op_code out
module bf_decode
    import bf_pkg::*;
(
    input  logic [7:0] data,
    output logic       is_op,
    output op_t        op_code
);
    always_comb begin
        is_op   = 1'b1;
        op_code = INC;
        case (data)
            CH_INC:   op_code = INC;
            CH_DEC:   op_code = DEC;
            CH_RIGHT: op_code = RIGHT;
            CH_LEFT:  op_code = LEFT;
            CH_OUT:   op_code = OUT;
            CH_IN:    op_code = IN;
            CH_OPEN:  op_code = LOOP_OPEN;
            CH_CLOSE: op_code = LOOP_CLOSE;
            default:  is_op   = 1'b0;
        endcase
    end
endmodule

// File: rtl/bf_fetch_unit.sv
// bf_fetch_unit: walks the PC over program memory, issues decoded ops and scans for matching brackets
// ports: start pulse; mem_active/mem_read/mem_addr/mem_rdata to program memory;
//        op_valid/op_code/op_pc/op_ready/cell_zero to execute; halted/error status
module bf_fetch_unit
    import bf_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int PROG_LEN = 512,
    parameter int DEPTH_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              mem_active,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              op_valid,
    output logic [2:0]        op_code,
    output logic [ADDR_W-1:0] op_pc,
    input  logic              op_ready,
    input  logic              cell_zero,
    output logic              halted,
    output logic              error
);
    localparam logic [ADDR_W-1:0] END_ADDR = ADDR_W'(PROG_LEN);
    state_t              state, state_n;
    logic [ADDR_W-1:0]   pc, pc_n, scan, scan_n, op_pc_n;
    logic [DEPTH_W-1:0]  depth, depth_n, depth_upd;
    logic                fwd, fwd_n, err, err_n, dec_is_op, nest, unnest;
    op_t                 code, code_n, dec_code;

    bf_decode u_decode (.data(mem_rdata), .is_op(dec_is_op), .op_code(dec_code));

    // the bracket that deepens nesting depends on scan direction
    assign nest      = dec_is_op && dec_code == (fwd ? LOOP_OPEN : LOOP_CLOSE);
    assign unnest    = dec_is_op && dec_code == (fwd ? LOOP_CLOSE : LOOP_OPEN);
    assign depth_upd = nest ? depth + 1'b1 : unnest ? depth - 1'b1 : depth;
    assign mem_read  = 1'b1;
    assign op_code   = code;
    assign error     = err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= '0;
            scan  <= '0;
            depth <= '0;
            fwd   <= 1'b0;
            code  <= INC;
            op_pc <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            scan  <= scan_n;
            depth <= depth_n;
            fwd   <= fwd_n;
            code  <= code_n;
            op_pc <= op_pc_n;
            err   <= err_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        scan_n     = scan;
        depth_n    = depth;
        fwd_n      = fwd;
        code_n     = code;
        op_pc_n    = op_pc;
        err_n      = err;
        mem_active = 1'b0;
        mem_addr   = '0;
        op_valid   = 1'b0;
        halted     = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                pc_n    = '0;
                state_n = S_FETCH;
            end
            S_FETCH: begin
                mem_active = 1'b1;
                mem_addr   = pc;
                state_n    = S_DECODE;
            end
            S_DECODE: begin
                if (pc == END_ADDR || mem_rdata == CH_NUL) state_n = S_HALT;
                else if (dec_is_op) begin
                    code_n  = dec_code;
                    op_pc_n = pc;
                    state_n = S_ISSUE;
                end else begin
                    pc_n    = pc + 1'b1;
                    state_n = S_FETCH;
                end
            end
            S_ISSUE: begin
                op_valid = 1'b1;
                if (op_ready) begin
                    if (code == LOOP_OPEN && cell_zero) begin
                        depth_n = DEPTH_W'(1);
                        scan_n  = pc + 1'b1;
                        fwd_n   = 1'b1;
                        state_n = S_SCAN_REQ;
                    end else if (code == LOOP_CLOSE && !cell_zero) begin
                        if (pc == '0) begin
                            err_n   = 1'b1;
                            state_n = S_HALT;
                        end else begin
                            depth_n = DEPTH_W'(1);
                            scan_n  = pc - 1'b1;
                            fwd_n   = 1'b0;
                            state_n = S_SCAN_REQ;
                        end
                    end else begin
                        pc_n    = pc + 1'b1;
                        state_n = S_FETCH;
                    end
                end
            end
            S_SCAN_REQ: begin
                mem_active = 1'b1;
                mem_addr   = scan;
                state_n    = S_SCAN_CHK;
            end
            S_SCAN_CHK: begin
                depth_n = depth_upd;
                if (fwd && (scan == END_ADDR || mem_rdata == CH_NUL)) begin
                    err_n   = 1'b1;
                    state_n = S_HALT;
                end else if (nest && &depth) begin
                    err_n   = 1'b1;
                    state_n = S_HALT;
                end else if (depth_upd == '0) begin
                    pc_n    = scan + 1'b1;
                    state_n = S_FETCH;
                end else if (!fwd && scan == '0) begin
                    err_n   = 1'b1;
                    state_n = S_HALT;
                end else begin
                    scan_n  = fwd ? scan + 1'b1 : scan - 1'b1;
                    state_n = S_SCAN_REQ;
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (start) begin
                    err_n   = 1'b0;
                    pc_n    = '0;
                    state_n = S_FETCH;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_bf_fetch_unit.sv
// tb_bf_fetch_unit: runs small programs against a reference interpreter and a toy execute stage
module tb_bf_fetch_unit;
    localparam int AW = 16;
    localparam int PL = 512;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, op_ready = 1'b0, cell_zero = 1'b0;
    logic          mem_active, mem_read, op_valid, halted, error;
    logic [AW-1:0] mem_addr, op_pc;
    logic [7:0]    mem_rdata = 8'h00;
    logic [2:0]    op_code;

    always #5 clk = ~clk;

    bf_fetch_unit #(.ADDR_W(AW), .PROG_LEN(PL), .DEPTH_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_active(mem_active), .mem_read(mem_read),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .op_valid(op_valid), .op_code(op_code),
        .op_pc(op_pc), .op_ready(op_ready), .cell_zero(cell_zero), .halted(halted), .error(error)
    );

    int         checks = 0, errors = 0;
    logic [7:0] mem [0:1023];
    logic [7:0] tape [16];
    int         ptr, stall_pc, stall_left, valid_cnt, model_n;
    int         exp_code[$], exp_pc[$], obs_code[$], obs_pc[$], req_log[$];
    logic       exp_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int code_of(input logic [7:0] b);
        case (b)
            "+": return 0;
            "-": return 1;
            ">": return 2;
            "<": return 3;
            ".": return 4;
            ",": return 5;
            "[": return 6;
            "]": return 7;
            default: return -1;
        endcase
    endfunction

    function automatic int obs_at(input int i);
        return (i < obs_code.size()) ? obs_code[i] * 10000 + obs_pc[i] : -1;
    endfunction

    // reference interpreter: bracket matching by stack, then program-level execution
    task automatic build_model(input int tape0);
        int st[$];
        int m[int];
        logic [7:0] t [16];
        int pc, p, c;
        bit jump;
        exp_code.delete(); exp_pc.delete(); exp_err = 0; model_n = 0;
        for (int i = 0; i < PL && mem[i] != 8'h00; i++) begin
            if (mem[i] == "[") st.push_back(i);
            else if (mem[i] == "]" && st.size() > 0) begin
                m[i] = st[$];
                m[st[$]] = i;
                void'(st.pop_back());
            end
        end
        foreach (t[i]) t[i] = 8'h00;
        t[0] = 8'(tape0);
        pc = 0; p = 0;
        for (int steps = 0; steps < 4000; steps++) begin
            if (pc >= PL || mem[pc] == 8'h00) break;
            c = code_of(mem[pc]);
            if (c < 0) begin pc++; continue; end
            exp_code.push_back(c); exp_pc.push_back(pc); model_n++;
            jump = (c == 6 && t[p] == 0) || (c == 7 && t[p] != 0);
            if (c == 0) t[p] = t[p] + 1;
            if (c == 1) t[p] = t[p] - 1;
            if (c == 2) p = (p + 1) % 16;
            if (c == 3) p = (p + 15) % 16;
            if (jump) begin
                if (!m.exists(pc)) begin exp_err = 1; break; end
                pc = m[pc] + 1;
            end else pc++;
        end
    endtask

    task automatic tick();
        logic req, hs;
        logic [AW-1:0] a;
        logic [2:0] c;
        req = mem_active; a = mem_addr; hs = op_valid && op_ready; c = op_code;
        @(posedge clk);
        #1;
        mem_rdata = (req && a < 1024) ? mem[a[9:0]] : 8'h00;
        if (req) req_log.push_back(int'(a));
        if (hs) begin
            if (c == 3'd0) tape[ptr] = tape[ptr] + 1;
            if (c == 3'd1) tape[ptr] = tape[ptr] - 1;
            if (c == 3'd2) ptr = (ptr + 1) % 16;
            if (c == 3'd3) ptr = (ptr + 15) % 16;
            cell_zero = (tape[ptr] == 8'h00);
        end
    endtask

    // per-cycle comparison against the model queue; also plays the execute stage's op_ready
    task automatic observe();
        chk("mem_read", mem_read, 1);
        if (op_valid) begin
            chk("mem_idle_in_issue", mem_active, 0);
            if (exp_code.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_op: got code %0d pc %0d expected none", op_code, op_pc);
            end else begin
                chk("op_code", op_code, exp_code[0]);
                chk("op_pc", op_pc, exp_pc[0]);
            end
            if (int'(op_pc) == stall_pc) valid_cnt++;
            op_ready = !(int'(op_pc) == stall_pc && stall_left > 0);
            if (!op_ready) stall_left--;
            else begin
                obs_code.push_back(int'(op_code)); obs_pc.push_back(int'(op_pc));
                if (exp_code.size() > 0) begin void'(exp_code.pop_front()); void'(exp_pc.pop_front()); end
            end
        end else op_ready = 1'b0;
    endtask

    task automatic load(input string s, input int tape0, input int spc, input int sn);
        foreach (mem[i]) mem[i] = 8'h00;
        for (int i = 0; i < s.len(); i++) mem[i] = s[i];
        build_model(tape0);
        foreach (tape[i]) tape[i] = 8'h00;
        tape[0] = 8'(tape0); ptr = 0; cell_zero = (tape0 == 0);
        stall_pc = spc; stall_left = sn; valid_cnt = 0;
        obs_code.delete(); obs_pc.delete(); req_log.delete();
        start = 1'b1; observe(); tick(); start = 1'b0;
    endtask

    task automatic run_prog(input string s, input int tape0, input int spc, input int sn);
        int n;
        load(s, tape0, spc, sn);
        n = 0;
        while (!halted && n < 3000) begin observe(); tick(); n++; end
        chk("halt_reached", halted, 1);
        chk("error_flag", error, exp_err);
        chk("ops_outstanding", exp_code.size(), 0);
    endtask

    initial begin
        string s;
        int n;
        repeat (2) tick();
        chk("rst_mem_active", mem_active, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_op_code", op_code, 0);
        chk("rst_op_pc", op_pc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_error", error, 0);
        rst_n = 1'b1;
        tick();

        run_prog("+>.", 0, -1, 0);
        chk("m1_len", model_n, 3);
        chk("t1_op0", obs_at(0), 0);
        chk("t1_op1", obs_at(1), 20001);
        chk("t1_op2", obs_at(2), 40002);
        chk("t1_err", error, 0);

        run_prog("a+ b", 0, -1, 0);
        chk("t2_count", obs_code.size(), 1);
        chk("t2_op0", obs_at(0), 1);
        chk("t2_last_req", req_log.size() > 0 ? req_log[$] : -1, 4);

        run_prog("[+]", 0, -1, 0);
        chk("t3_count", obs_code.size(), 1);
        chk("t3_op0", obs_at(0), 60000);
        chk("t3_reqs", req_log.size(), 4);
        chk("t3_req1", req_log.size() > 3 ? req_log[1] * 100 + req_log[2] * 10 + req_log[3] : -1, 123);

        run_prog("+[-]", 1, -1, 0);
        chk("m4_len", model_n, 6);
        chk("t4_op2", obs_at(2), 10002);
        chk("t4_op4", obs_at(4), 10002);
        chk("t4_op5", obs_at(5), 70003);
        chk("t4_err", error, 0);

        run_prog("+>.", 0, 1, 3);
        chk("t5_valid_cycles", valid_cnt, 4);
        chk("t5_count", obs_code.size(), 3);
        chk("t5_op1", obs_at(1), 20001);

        run_prog("[[]", 0, -1, 0);
        chk("t6_error", error, 1);
        chk("t6_halted", halted, 1);
        chk("t6_count", obs_code.size(), 1);
        start = 1'b1; observe(); tick(); start = 1'b0;
        chk("t6_restart_halted", halted, 0);
        chk("t6_restart_error", error, 0);
        chk("t6_restart_active", mem_active, 1);
        chk("t6_restart_addr", mem_addr, 0);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();

        run_prog("x]", 1, -1, 0);
        chk("t7_error", error, 1);
        chk("t7_op0", obs_at(0), 70001);

        s = "";
        for (int i = 0; i < PL; i++) s = {s, "x"};
        s = {s, "+"};
        run_prog(s, 0, -1, 0);
        chk("t8_count", obs_code.size(), 0);
        chk("t8_last_req", req_log.size() > 0 ? req_log[$] : -1, PL);
        chk("t8_error", error, 0);

        s = "[";
        for (int i = 0; i < 20; i++) s = {s, "+"};
        s = {s, "]"};
        load(s, 0, -1, 0);
        n = 0;
        while (!(mem_active && mem_addr == 5) && n < 200) begin observe(); tick(); n++; end
        chk("t9_scan_reached", mem_addr, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("t9_rst_active", mem_active, 0);
        chk("t9_rst_valid", op_valid, 0);
        chk("t9_rst_addr", mem_addr, 0);
        chk("t9_rst_halted", halted, 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("t9_idle_active", mem_active, 0);
        chk("t9_idle_valid", op_valid, 0);

        run_prog("+", 0, -1, 0);
        chk("t10_op0", obs_at(0), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
